spi_bus_scheduler: RTL and testbench

//  Round-robin scheduler sharing one SPI mode-1 bus between N_REQ requesters.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_rr_arbiter.sv | 37 +++
 rtl/spi_bus_scheduler.sv | 172 +++++++++++++++++
 tb/tb_spi_bus_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI bus scheduler.
//   sched_state_t  : scheduler FSM encoding (IDLE, SHIFT, DONE, GAP)
//   DEFAULT_DATA_W : default transaction width in bits
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    GAP   = 2'd3
  } sched_state_t;

  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first set req bit at or after rr_ptr, wrapping modulo N_REQ.
// Ports:
//   req       in   N_REQ   request vector
//   rr_ptr    in   IDX_W   highest-priority index for this arbitration
//   grant     out  N_REQ   one-hot winner (all zero when no request)
//   grant_idx out  IDX_W   binary index of the winner
//   grant_vld out  1       at least one request is pending
module spi_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    // Walk the ring starting at rr_ptr; the first hit wins.
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!grant_vld && req[idx]) begin
        grant_vld  = 1'b1;
        grant_idx  = IDX_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_bus_scheduler.sv
// Round-robin scheduler sharing one SPI mode-1 bus between N_REQ requesters.
// Requester i owns slave select ss_n[i]. The winner's word is shifted out
// LSB-first on mosi while miso is sampled; the received word is returned on
// rx_data and done[i] pulses for one cycle.
//
// Handshake: req[i] is a level request. The requester holds req[i] and its
// tx_data slice stable until gnt[i] rises; gnt[i] is the acceptance. After
// that, dropping req[i] does not abort the transfer, and a req[i] still high
// once done[i] has pulsed counts as a fresh request.
//
// Ports:
//   sclk     in   1             bus clock, all logic on posedge
//   rst      in   1             synchronous active-high reset
//   req      in   N_REQ         request per requester
//   tx_data  in   N_REQ*DATA_W  word per requester, slice i = [i*DATA_W +: DATA_W]
//   miso     in   1             serial data from the selected slave
//   gnt      out  N_REQ         one-hot grant, high during the transfer
//   ss_n     out  N_REQ         active-low selects, always ~gnt
//   mosi     out  1             serial data to the selected slave
//   rx_data  out  DATA_W        last received word, held until next done
//   done     out  N_REQ         one-cycle completion pulse
//   busy     out  1             FSM not in IDLE
module spi_bus_scheduler
  import spi_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int GAP_CYC = 2
) (
  input  logic                      sclk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   tx_data,
  input  logic                      miso,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          ss_n,
  output logic                      mosi,
  output logic [DATA_W-1:0]         rx_data,
  output logic [N_REQ-1:0]          done,
  output logic                      busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  sched_state_t      state_q,   state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [N_REQ-1:0]  gnt_q,     gnt_d;
  logic [N_REQ-1:0]  done_q,    done_d;
  logic [IDX_W-1:0]  owner_q,   owner_d;
  logic [IDX_W-1:0]  rr_ptr_q,  rr_ptr_d;
  logic              mosi_q,    mosi_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_vld;
  logic [DATA_W-1:0] rx_next;
  logic [CNT_W-1:0]  cnt_next;

  spi_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .grant     (arb_gnt),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    mosi_d     = mosi_q;
    done_d     = '0;

    // Received word including the bit sampled at this edge, so the last
    // SHIFT edge can publish the complete word directly.
    rx_next            = rx_shift_q;
    rx_next[bit_cnt_q] = miso;
    cnt_next           = bit_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          tx_shift_d = tx_data[int'(arb_idx)*DATA_W +: DATA_W];
          mosi_d     = tx_data[int'(arb_idx)*DATA_W];
          gnt_d      = arb_gnt;
          owner_d    = arb_idx;
          bit_cnt_d  = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        rx_shift_d = rx_next;
        if (bit_cnt_q == CNT_W'(DATA_W-1)) begin
          gnt_d           = '0;
          mosi_d          = 1'b0;
          rx_data_d       = rx_next;
          done_d[owner_q] = 1'b1;
          // Served requester drops to lowest priority next time.
          rr_ptr_d        = (owner_q == IDX_W'(N_REQ-1)) ? '0 : owner_q + 1'b1;
          state_d         = DONE;
        end else begin
          bit_cnt_d = cnt_next;
          mosi_d    = tx_shift_q[cnt_next];
        end
      end
      DONE: begin
        gap_cnt_d = '0;
        state_d   = (GAP_CYC > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (int'(gap_cnt_q) >= GAP_CYC-1) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      mosi_q     <= mosi_d;
    end
  end

  // Selects derive from the registered grant so they can never disagree.
  assign gnt     = gnt_q;
  assign ss_n    = ~gnt_q;
  assign mosi    = mosi_q;
  assign rx_data = rx_data_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_bus_scheduler.sv
module tb_spi_bus_scheduler;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 8;
  localparam int GAP_CYC = 2;

  logic                    sclk = 1'b0;
  logic                    rst  = 1'b1;
  logic [N_REQ-1:0]        req  = '0;
  logic [N_REQ*DATA_W-1:0] tx_data = '0;
  logic                    miso;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        ss_n;
  logic                    mosi;
  logic [DATA_W-1:0]       rx_data;
  logic [N_REQ-1:0]        done;
  logic                    busy;

  logic loop_mode  = 1'b1;
  logic miso_fixed = 1'b0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // ---------------- clock / reset ----------------
  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  // Loopback reads mosi as it stood before the edge, like a real slave echo.
  assign miso = loop_mode ? mosi : miso_fixed;

  spi_bus_scheduler #(
    .N_REQ   (N_REQ),
    .DATA_W  (DATA_W),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .sclk    (sclk),
    .rst     (rst),
    .req     (req),
    .tx_data (tx_data),
    .miso    (miso),
    .gnt     (gnt),
    .ss_n    (ss_n),
    .mosi    (mosi),
    .rx_data (rx_data),
    .done    (done),
    .busy    (busy)
  );

  // ---------------- driver / wait tasks ----------------
  task automatic do_reset();
    @(negedge sclk);
    rst = 1'b1;
    req = '0;
    @(negedge sclk);
    rst = 1'b0;
  endtask

  // Waits for the current grant (if any) to end, then for the next grant.
  task automatic wait_grant(output logic [N_REQ-1:0] g, output int at_cyc, output bit ok);
    int n;
    ok = 1'b0;
    g = '0;
    at_cyc = 0;
    n = 0;
    while (gnt !== '0 && n < 40) begin
      @(negedge sclk);
      n++;
    end
    n = 0;
    while (!ok && n < 40) begin
      @(negedge sclk);
      n++;
      if (gnt !== '0) begin
        ok = 1'b1;
        g = gnt;
        at_cyc = cyc;
      end
    end
  endtask

  task automatic wait_done(output logic [N_REQ-1:0] d, output bit ok);
    int n;
    ok = 1'b0;
    d = '0;
    n = 0;
    while (!ok && n < 30) begin
      @(negedge sclk);
      n++;
      if (done !== '0) begin
        ok = 1'b1;
        d = done;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 40) begin
      @(negedge sclk);
      n++;
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge sclk);
    @(negedge sclk);
    checks++;
    if (gnt !== 4'b0000 || ss_n !== 4'b1111 || mosi !== 1'b0 || rx_data !== 8'h00 ||
        done !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset: gnt=%b ss_n=%b mosi=%b rx=%h done=%b busy=%b, want 0000 1111 0 00 0000 0",
               gnt, ss_n, mosi, rx_data, done, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic exp_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit ok;
    loop_mode = 1'b1;
    @(negedge sclk);
    tx_data[1*DATA_W +: DATA_W] = 8'hA5;
    req = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      @(negedge sclk);
      if (k == 0) req = 4'b0000;
      checks++;
      if (ss_n !== 4'b1101 || gnt !== 4'b0010 || busy !== 1'b1) begin
        failures++;
        $display("FAIL single_select bit%0d: ss_n=%b gnt=%b busy=%b, want 1101 0010 1", k, ss_n, gnt, busy);
      end
      checks++;
      if (mosi !== exp_bits[k]) begin
        failures++;
        $display("FAIL single_mosi bit%0d: got %b want %b", k, mosi, exp_bits[k]);
      end
    end
    @(negedge sclk);
    checks++;
    if (done !== 4'b0010 || rx_data !== 8'hA5 || ss_n !== 4'b1111 || gnt !== 4'b0000 || mosi !== 1'b0) begin
      failures++;
      $display("FAIL single_done: done=%b rx=%h ss_n=%b gnt=%b mosi=%b, want 0010 a5 1111 0000 0",
               done, rx_data, ss_n, gnt, mosi);
    end
    @(negedge sclk);
    checks++;
    if (done !== 4'b0000 || busy !== 1'b1 || rx_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_after: done=%b busy=%b rx=%h, want 0000 1 a5", done, busy, rx_data);
    end
    // Two GAP cycles then back to IDLE.
    @(negedge sclk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL single_gap: busy=%b want 1", busy);
    end
    @(negedge sclk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [N_REQ-1:0] exp_q[$];
    logic [N_REQ-1:0] g;
    logic [N_REQ-1:0] exp_g;
    int at_cyc;
    int prev_cyc;
    bit ok;
    do_reset();
    loop_mode = 1'b1;
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    tx_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    prev_cyc = 0;
    for (int n = 0; n < 5; n++) begin
      wait_grant(g, at_cyc, ok);
      exp_g = exp_q.pop_front();
      checks++;
      if (!ok || g !== exp_g || ss_n !== ~exp_g) begin
        failures++;
        $display("FAIL rr_order #%0d: gnt=%b ss_n=%b seen=%0d, want gnt %b", n, g, ss_n, ok, exp_g);
      end
      if (n > 0) begin
        checks++;
        if (at_cyc - prev_cyc != 12) begin
          failures++;
          $display("FAIL rr_spacing #%0d: got %0d cycles want 12", n, at_cyc - prev_cyc);
        end
      end
      prev_cyc = at_cyc;
    end
    req = 4'b0000;
    wait_idle(ok);
    checks++;
    if (!ok || rx_data !== 8'h11) begin
      failures++;
      $display("FAIL rr_last_rx: rx=%h idle=%0d, want 11 1", rx_data, ok);
    end
  endtask

  task automatic test_wrap();
    logic [N_REQ-1:0] g;
    logic [N_REQ-1:0] d;
    int at_cyc;
    bit ok;
    do_reset();
    loop_mode = 1'b1;
    tx_data = {8'h00, 8'h77, 8'h00, 8'h5A};
    req = 4'b0100;
    wait_grant(g, at_cyc, ok);
    checks++;
    if (!ok || g !== 4'b0100) begin
      failures++;
      $display("FAIL wrap_first: gnt=%b want 0100", g);
    end
    req = 4'b0101;
    wait_grant(g, at_cyc, ok);
    checks++;
    if (!ok || g !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_second: gnt=%b want 0001", g);
    end
    req = 4'b0000;
    wait_done(d, ok);
    checks++;
    if (!ok || d !== 4'b0001 || rx_data !== 8'h5A) begin
      failures++;
      $display("FAIL wrap_done: done=%b rx=%h, want 0001 5a", d, rx_data);
    end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    logic [N_REQ-1:0] g;
    int at_cyc;
    bit ok;
    bit saw_done;
    loop_mode = 1'b1;
    tx_data[3*DATA_W +: DATA_W] = 8'h3C;
    req = 4'b1000;
    wait_grant(g, at_cyc, ok);
    repeat (4) @(negedge sclk);
    checks++;
    if (!ok || ss_n !== 4'b0111 || busy !== 1'b1 || rx_data !== 8'h5A) begin
      failures++;
      $display("FAIL midrst_before: ss_n=%b busy=%b rx=%h, want 0111 1 5a", ss_n, busy, rx_data);
    end
    rst = 1'b1;
    req = 4'b0000;
    @(negedge sclk);
    checks++;
    if (ss_n !== 4'hF || gnt !== 4'b0000 || done !== 4'b0000 || rx_data !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_after: ss_n=%b gnt=%b done=%b rx=%h busy=%b, want 1111 0000 0000 00 0",
               ss_n, gnt, done, rx_data, busy);
    end
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge sclk);
      if (done !== 4'b0000 || busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL midrst_quiet: activity after reset, want none");
    end
  endtask

  task automatic test_miso_ones();
    logic [N_REQ-1:0] g;
    logic [N_REQ-1:0] d;
    int at_cyc;
    bit ok;
    bit bad_mosi;
    loop_mode  = 1'b0;
    miso_fixed = 1'b1;
    tx_data[0 +: DATA_W] = 8'h00;
    req = 4'b0001;
    wait_grant(g, at_cyc, ok);
    req = 4'b0000;
    bad_mosi = (mosi !== 1'b0);
    for (int k = 1; k < 8; k++) begin
      @(negedge sclk);
      if (mosi !== 1'b0) bad_mosi = 1'b1;
    end
    checks++;
    if (!ok || g !== 4'b0001 || bad_mosi) begin
      failures++;
      $display("FAIL ones_mosi: gnt=%b mosi_nonzero=%0d, want 0001 0", g, bad_mosi);
    end
    wait_done(d, ok);
    checks++;
    if (!ok || d !== 4'b0001 || rx_data !== 8'hFF) begin
      failures++;
      $display("FAIL ones_rx: done=%b rx=%h, want 0001 ff", d, rx_data);
    end
    wait_idle(ok);
    loop_mode = 1'b1;
  endtask

  task automatic test_req_drop();
    logic [N_REQ-1:0] g;
    logic [N_REQ-1:0] d;
    int at_cyc;
    bit ok;
    loop_mode = 1'b1;
    tx_data[3*DATA_W +: DATA_W] = 8'hC3;
    req = 4'b1000;
    wait_grant(g, at_cyc, ok);
    @(negedge sclk);
    req = 4'b0000;
    checks++;
    if (!ok || g !== 4'b1000 || gnt !== 4'b1000) begin
      failures++;
      $display("FAIL drop_grant: gnt=%b want 1000", gnt);
    end
    wait_done(d, ok);
    checks++;
    if (!ok || d !== 4'b1000 || rx_data !== 8'hC3) begin
      failures++;
      $display("FAIL drop_done: done=%b rx=%h, want 1000 c3", d, rx_data);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL drop_idle: busy=%b want 0", busy);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_miso_ones();
    test_req_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
